oflow_dma_set_feeder: RTL
=========================

Name: oflow_dma_set_feeder

Overview:
- Upstream stage of the optical-flow core. Receives a per-frame stream of bounding-box feature vectors from the DMA/host, one per cycle.
- Packs the stream into sets of PE_NUM bboxes using ping-pong set banks.
- Presents each set on the core's set_of_bboxes_from_dma bus with the new_set_from_dma / ready_new_set handshake.
- Sequences frames with new_frame / ready_new_frame.

Parameters:
- PE_NUM, 24, bboxes per set (number of PEs).
- BBOX_W, 145, width of one bbox feature vector.
- NBOX_W, 9, width of the bbox count (0..256).
- SET_W, 4, width of the set index (max 11 sets per frame).

Ports:
- clk  in  1  core clock.
- reset_N  in  1  asynchronous active-low reset.
- frame_start  in  1  host pulse: a new frame is pending; samples num_of_bbox_in_frame.
- num_of_bbox_in_frame  in  NBOX_W  bbox count of the pending frame, 0..256.
- frame_busy  out  1  high from frame_start acceptance until frame_done.
- bbox_in  in  BBOX_W  streamed bbox vector.
- bbox_valid  in  1  bbox_in valid.
- bbox_ready  out  1  feeder accepts bbox_in this cycle.
- ready_new_frame  in  1  core ready for a new frame.
- new_frame  out  1  one-cycle pulse to core: frame begins.
- ready_new_set  in  1  core ready for a new set.
- new_set_from_dma  out  1  one-cycle pulse: a set is valid on the bus.
- set_of_bboxes_from_dma  out  PE_NUM x BBOX_W  presented set.
- set_idx  out  SET_W  index of the presented set within the frame.
- frame_done  out  1  one-cycle pulse after the last set of the frame is handed over.

Behaviour:
- Reset (async, reset_N low):
  - State IDLE; both banks and their fill counters cleared; set_of_bboxes_from_dma all zero.
  - bbox_ready, new_frame, new_set_from_dma, frame_done, frame_busy all 0; set_idx 0.
- A reset asserted mid-frame aborts the frame. Data already accepted is discarded and no partial set is presented.
- States:
  - IDLE: frame_start latches num_of_bbox_in_frame into remain and goes to FRAME_REQ. frame_start in any other state is ignored.
  - FRAME_REQ: when ready_new_frame is high, pulse new_frame for one cycle, then go to FILL. If remain==0, frame_done pulses in the cycle after new_frame and the FSM returns to IDLE without presenting any set.
  - FILL:
    - bbox_ready = (fill bank not full) AND (remain_to_accept > 0).
    - A transfer (bbox_valid & bbox_ready) writes bbox_in to fill_bank[wr_ptr], increments wr_ptr, and decrements remain_to_accept.
    - The bank is complete when wr_ptr==PE_NUM or remain_to_accept reaches 0. Entries wr_ptr..PE_NUM-1 of a partial last set are zero.
    - A complete bank is marked full and the fill pointer swaps to the other bank if that bank is free. Otherwise bbox_ready stays low (back-pressure) until it frees.
  - Present (concurrent with FILL):
    - When a bank is full and ready_new_set is high, copy it to the output register, pulse new_set_from_dma, set set_idx, and free the bank.
    - New data reaches the output bus only in a handshake cycle; data is stable from one new_set_from_dma pulse until the next.
    - Latency: the last bbox of a set is accepted in cycle t; the earliest new_set_from_dma is cycle t+1.
    - If the last transfer of a set and ready_new_set coincide, the set is presented the following cycle.
  - DRAIN: entered after the final bbox is accepted. Stays until every full bank has been presented. frame_done pulses in the cycle after the final new_set_from_dma, then the FSM goes to IDLE and frame_busy drops.
- Set count = ceil(n/PE_NUM); set_idx runs 0..count-1, and wraps to 0 at each new frame.
- new_set_from_dma is never asserted while ready_new_set is low. With both banks full and ready_new_set low, the feeder holds everything indefinitely.
- bbox_in transfers beyond num_of_bbox_in_frame are not accepted (bbox_ready low).

Decomposition:
- Package oflow_dma_feeder_pkg:
  - state enum {IDLE, FRAME_REQ, FILL, DRAIN}.
  - Constants PE_NUM, BBOX_W, NBOX_W, SET_W.
  - Typedef bbox_t, and set_t as an array of PE_NUM bbox_t.
- One natural sub-module: oflow_set_bank, holding one PE_NUM-entry bank with write pointer, full flag, clear, and zero-fill on clear.
- The top level instantiates two oflow_set_bank instances plus the FSM and the present logic.

Test Plan:
- n=48, ready_new_set tied high, bbox_valid continuous -> new_frame once; new_set_from_dma at the cycle after bbox #23 and after bbox #47; set_idx 0 then 1; frame_done one cycle after the second pulse.
- n=30 -> two sets; set 1 entries 0..5 carry bboxes 24..29 and entries 6..23 are zero; frame_done asserted.
- n=0 -> new_frame pulse, no new_set_from_dma, frame_done in the next cycle, FSM back to IDLE.
- n=96, ready_new_set low for 100 cycles -> after 48 accepted bboxes both banks are full and bbox_ready=0. Releasing ready_new_set gives one pulse per handshake and in-order sets 0..3; bus data is unchanged between pulses.
- ready_new_frame held low for 20 cycles after frame_start -> no new_frame and bbox_ready=0 until it rises; a second frame_start in this window is ignored.
- reset_N dropped mid-set (bbox #10 of n=48) -> all outputs are zero immediately; after release the feeder is in IDLE and a fresh frame with n=24 produces exactly one set.

Source files
------------

// File: rtl/oflow_dma_feeder_pkg.sv
// Shared types and sizing for the optical-flow DMA set feeder.
package oflow_dma_feeder_pkg;

    localparam int PE_NUM = 24;
    localparam int BBOX_W = 145;
    localparam int NBOX_W = 9;
    localparam int SET_W  = 4;
    localparam int PTR_W  = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FRAME_REQ = 2'd1,
        FILL      = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    typedef logic [BBOX_W-1:0] bbox_t;
    typedef bbox_t [PE_NUM-1:0] set_t;

    // One-hot bank enable for a ping-pong bank select.
    function automatic logic [1:0] bank_mask(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/oflow_set_bank.sv
// One ping-pong set bank: PE_NUM bbox entries, write pointer and full flag.
module oflow_set_bank
    import oflow_dma_feeder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [BBOX_W-1:0]        wr_data,
    input  logic                     close,
    input  logic                     clr,
    output logic [PE_NUM*BBOX_W-1:0] data,
    output logic [PTR_W-1:0]         wr_ptr,
    output logic                     full
);

    set_t             mem_r;
    logic [PTR_W-1:0] ptr_r;
    logic             full_r;

    // Clearing zeroes every entry so a partial last set is zero-padded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r  <= '0;
            ptr_r  <= '0;
            full_r <= 1'b0;
        end else if (clr) begin
            mem_r  <= '0;
            ptr_r  <= '0;
            full_r <= 1'b0;
        end else begin
            if (wr_en && !full_r) begin
                mem_r[ptr_r] <= wr_data;
                ptr_r        <= ptr_r + PTR_W'(1);
            end
            if (close) begin
                full_r <= 1'b1;
            end
        end
    end

    assign data   = mem_r;
    assign wr_ptr = ptr_r;
    assign full   = full_r;

endmodule

// File: rtl/oflow_dma_set_feeder.sv
// Packs the per-frame bbox stream into PE_NUM-wide sets and hands them to the core.
module oflow_dma_set_feeder
    import oflow_dma_feeder_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_N,
    input  logic                     frame_start,
    input  logic [NBOX_W-1:0]        num_of_bbox_in_frame,
    output logic                     frame_busy,
    input  logic [BBOX_W-1:0]        bbox_in,
    input  logic                     bbox_valid,
    output logic                     bbox_ready,
    input  logic                     ready_new_frame,
    output logic                     new_frame,
    input  logic                     ready_new_set,
    output logic                     new_set_from_dma,
    output logic [PE_NUM*BBOX_W-1:0] set_of_bboxes_from_dma,
    output logic [SET_W-1:0]         set_idx,
    output logic                     frame_done
);

    state_t                   state_r, state_s;
    logic [NBOX_W-1:0]        remain_r;
    logic                     fill_sel_r, pres_sel_r, new_frame_r, done_r;
    logic [SET_W-1:0]         set_cnt_r, idx_hold_r;
    logic [PE_NUM*BBOX_W-1:0] out_r;
    logic [PE_NUM*BBOX_W-1:0] bank_data [2];
    logic [PTR_W-1:0]         bank_ptr [2];
    logic [1:0]               bank_full, bank_wr, bank_close, bank_clr;
    logic                     ready_s, xfer_s, last_in_set_s, last_in_frame_s, hs_s, done_s;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        oflow_set_bank u_bank (
            .clk     (clk),
            .rst_n   (reset_N),
            .wr_en   (bank_wr[b]),
            .wr_data (bbox_in),
            .close   (bank_close[b]),
            .clr     (bank_clr[b]),
            .data    (bank_data[b]),
            .wr_ptr  (bank_ptr[b]),
            .full    (bank_full[b])
        );
    end

    // Accept/present decisions and next state; a full bank is presented while ready_new_set is high.
    always_comb begin
        ready_s         = 1'b0;
        hs_s            = 1'b0;
        done_s          = 1'b0;
        state_s         = state_r;
        if (state_r == FILL) begin
            ready_s = !bank_full[fill_sel_r] && (remain_r != '0);
        end else begin
            ready_s = 1'b0;
        end
        xfer_s          = bbox_valid && ready_s;
        last_in_frame_s = xfer_s && (remain_r == NBOX_W'(1));
        last_in_set_s   = last_in_frame_s ||
                          (xfer_s && (bank_ptr[fill_sel_r] == PTR_W'(PE_NUM - 1)));
        if (((state_r == FILL) || (state_r == DRAIN)) && !done_r) begin
            hs_s = bank_full[pres_sel_r] && ready_new_set;
        end else begin
            hs_s = 1'b0;
        end
        bank_wr    = xfer_s        ? bank_mask(fill_sel_r) : 2'b00;
        bank_close = last_in_set_s ? bank_mask(fill_sel_r) : 2'b00;
        bank_clr   = hs_s          ? bank_mask(pres_sel_r) : 2'b00;
        // Done once nothing is left to present after this cycle's handover.
        if ((state_r == DRAIN) && !done_r) begin
            done_s = ((bank_full & ~bank_clr) == 2'b00);
        end else begin
            done_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (frame_start) state_s = FRAME_REQ;
                else             state_s = IDLE;
            end
            FRAME_REQ: begin
                if (ready_new_frame) state_s = (remain_r == '0) ? DRAIN : FILL;
                else                 state_s = FRAME_REQ;
            end
            FILL: begin
                if (last_in_frame_s) state_s = DRAIN;
                else                 state_s = FILL;
            end
            DRAIN: begin
                if (done_r) state_s = IDLE;
                else        state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Frame sequencing, bbox budget and bank ping-pong pointers.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_r     <= IDLE;
            remain_r    <= '0;
            fill_sel_r  <= 1'b0;
            pres_sel_r  <= 1'b0;
            new_frame_r <= 1'b0;
            done_r      <= 1'b0;
            set_cnt_r   <= '0;
        end else begin
            state_r     <= state_s;
            new_frame_r <= (state_r == FRAME_REQ) && ready_new_frame;
            done_r      <= done_s;
            if ((state_r == IDLE) && frame_start) begin
                remain_r   <= num_of_bbox_in_frame;
                fill_sel_r <= 1'b0;
                pres_sel_r <= 1'b0;
                set_cnt_r  <= '0;
            end else begin
                if (xfer_s)        remain_r   <= remain_r - NBOX_W'(1);
                if (last_in_set_s) fill_sel_r <= !fill_sel_r;
                if (hs_s) begin
                    pres_sel_r <= !pres_sel_r;
                    set_cnt_r  <= set_cnt_r + SET_W'(1);
                end
            end
        end
    end

    // Holding copy of the last presented set and its index.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            out_r      <= '0;
            idx_hold_r <= '0;
        end else if (hs_s) begin
            out_r      <= bank_data[pres_sel_r];
            idx_hold_r <= set_cnt_r;
        end
    end

    // The handover cycle already shows the new set; afterwards the held copy keeps the bus stable.
    assign set_of_bboxes_from_dma = hs_s ? bank_data[pres_sel_r] : out_r;
    assign set_idx                = hs_s ? set_cnt_r : idx_hold_r;
    assign new_set_from_dma       = hs_s;
    assign bbox_ready             = ready_s;
    assign new_frame              = new_frame_r;
    assign frame_done             = done_r;
    assign frame_busy             = (state_r != IDLE);

endmodule
